// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - digit-serial MSB-first eq/gt/lt comparator with start/busy/done handshake
module serial_magnitude_comparator #(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 2,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NDIG = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CMP  = 1'b1;

  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_magnitude_comparator: WIDTH must be a nonzero multiple of DIGIT");
  end

  logic [0:0]       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             found_q, found_d;
  logic             fgt_q, fgt_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;

  logic [DIGIT-1:0] a_dig, b_dig;
  logic             diff, hit_found, hit_gt;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    found_d   = found_q;
    fgt_d     = fgt_q;
    done_d    = 1'b0;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    a_dig     = a_q[int'(idx_q) * DIGIT +: DIGIT];
    b_dig     = b_q[int'(idx_q) * DIGIT +: DIGIT];
    diff      = (a_dig != b_dig);
    // The first recorded difference wins; later digits only matter while nothing is recorded.
    hit_found = found_q | diff;
    hit_gt    = found_q ? fgt_q : (a_dig > b_dig);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order.
          a_d     = a ^ (signed_mode ? MSB_MASK : '0);
          b_d     = b ^ (signed_mode ? MSB_MASK : '0);
          idx_d   = IW'(NDIG - 1);
          found_d = 1'b0;
          fgt_d   = 1'b0;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        found_d = hit_found;
        fgt_d   = hit_gt;
        if (idx_q == '0 || (EARLY_EXIT != 0 && diff)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          eq_d    = ~hit_found;
          gt_d    = hit_found & hit_gt;
          lt_d    = hit_found & ~hit_gt;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      found_q <= 1'b0;
      fgt_q   <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      found_q <= found_d;
      fgt_q   <= fgt_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  assign busy = (state_q == S_CMP);
  assign done = done_q;
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - table-driven bench for serial_magnitude_comparator (early-exit and full-scan instances)
module tb_serial_magnitude_comparator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       signed_mode = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy1, done1, eq1, gt1, lt1;
  logic       busy0, done0, eq0, gt0, lt0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy1), .done(done1), .eq(eq1), .gt(gt1), .lt(lt1)
  );

  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy0), .done(done0), .eq(eq0), .gt(gt0), .lt(lt0)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sm;
    logic [2:0] egl;  // {eq, gt, lt}
    int         k1;   // latency with early exit; full scan is always 4
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  // Launch one transaction and measure both instances' latency and results.
  task automatic run_vec(input vec_t v, input int idx);
    int lat1, lat0;
    logic [2:0] r1, r0;
    lat1 = -1; lat0 = -1; r1 = '0; r0 = '0;
    @(negedge clk);
    a = v.a; b = v.b; signed_mode = v.sm; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~v.a; b = ~v.b; signed_mode = ~v.sm;
    for (int n = 0; n < 12; n++) begin
      if (done1 && lat1 < 0) begin lat1 = n; r1 = {eq1, gt1, lt1}; end
      if (done0 && lat0 < 0) begin lat0 = n; r0 = {eq0, gt0, lt0}; end
      if (lat1 >= 0 && lat0 >= 0) break;
      @(negedge clk);
    end
    check($sformatf("vec%0d_lat_ee1", idx), lat1, v.k1);
    check($sformatf("vec%0d_res_ee1", idx), int'(r1), int'(v.egl));
    check($sformatf("vec%0d_lat_ee0", idx), lat0, 4);
    check($sformatf("vec%0d_res_ee0", idx), int'(r0), int'(v.egl));
  endtask

  initial begin
    int seen_done;
    vecs[0] = '{8'hA5, 8'hA5, 1'b0, 3'b100, 4};
    vecs[1] = '{8'h80, 8'h7F, 1'b0, 3'b010, 1};
    vecs[2] = '{8'h80, 8'h7F, 1'b1, 3'b001, 1};
    vecs[3] = '{8'h12, 8'h13, 1'b0, 3'b001, 4};
    vecs[4] = '{8'hFF, 8'hFE, 1'b1, 3'b010, 4};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 3'b100, 4};
    vecs[6] = '{8'h34, 8'h24, 1'b0, 3'b010, 2};
    vecs[7] = '{8'h01, 8'h81, 1'b1, 3'b010, 1};
    vecs[8] = '{8'hC0, 8'hD0, 1'b0, 3'b001, 2};
    vecs[9] = '{8'h7F, 8'h80, 1'b1, 3'b010, 1};

    // Reset for two cycles with a start pulse inside it.
    @(negedge clk);
    start = 1'b1; a = 8'h11; b = 8'h22;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    check("rst_outputs", int'({busy1, done1, eq1, gt1, lt1}), 0);
    @(negedge clk);
    check("rst_no_busy", int'({busy1, busy0}), 0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // start held for six edges; a/b wiggle while busy; second op latched on done cycle.
    @(negedge clk);
    a = 8'h12; b = 8'h13; signed_mode = 1'b0; start = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      a = 8'hFF; b = 8'h00;
    end
    @(negedge clk);
    check("hold_done", int'({done1, busy1}), 2);
    check("hold_first_op", int'({eq1, gt1, lt1}), 1);
    a = 8'hA5; b = 8'hA5;
    @(negedge clk);
    start = 1'b0; a = 8'h00; b = 8'h01;
    check("b2b_busy", int'(busy1), 1);
    seen_done = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done1) seen_done = n + 1;
    end
    check("b2b_lat", seen_done, 4);
    check("b2b_res", int'({eq1, gt1, lt1}), 4);

    // Reset on the second CMP cycle discards the transaction.
    @(negedge clk);
    a = 8'h12; b = 8'h13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_state", int'({busy1, done1, eq1, gt1, lt1}), 0);
    seen_done = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (done1 || busy1) seen_done = 1;
    end
    check("midrst_quiet", seen_done, 0);
    run_vec(vecs[6], 10);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
